btn_conditioner: RTL

Input-conditioning stage between the Tiny Tapeout `ui_in[7:4]` push-button pins and the game state machine. It synchronizes each raw, asynchronous button into `clk`, rejects contact bounce with a per-channel stability counter, and emits clean debounced levels plus one-cycle press and release pulses. Optionally it also emits a long-press pulse. The game logic consumes only these conditioned signals, never raw pins.

---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_debounce_ch.sv | 109 ++++++++++
 rtl/btn_conditioner.sv | 37 +++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants and button-position names for the push-button conditioning slice.
// The long-press feature is enabled with the BTN_LONG_PRESS_EN macro.
package btn_pkg;

    localparam int unsigned BTN_N_DEF               = 4;
    localparam int unsigned BTN_DEBOUNCE_CYCLES_DEF = 100_000;    // 5 ms at 20 MHz
    localparam int unsigned BTN_LONG_CYCLES_DEF     = 20_000_000; // 1 s at 20 MHz

    // Button positions on ui_in[7:4], numbered from ui_in[4].
    typedef enum logic [1:0] {
        BTN_0 = 2'd0,
        BTN_1 = 2'd1,
        BTN_2 = 2'd2,
        BTN_3 = 2'd3
    } btn_idx_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, stability counter, debounced level and
// one-cycle press/release pulses; hold counter and long-press pulse under BTN_LONG_PRESS_EN.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = BTN_LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_debounce_ch: DEBOUNCE_CYCLES must be at least 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("btn_debounce_ch: LONG_CYCLES must be at least 1");
    end

    logic             sync1_q,   sync1_d;
    logic             sync2_q,   sync2_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             level_q,   level_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        // Terminal compare accepts the new level instead of incrementing, so the count never wraps.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d   = sync2_q;
                press_d   = sync2_q;
                release_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Parking the counter at LONG_CYCLES (one past the pulse point) suppresses repeat pulses.
    always_comb begin
        hold_d = '0;
        long_d = 1'b0;
        if (level_q) begin
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
            long_d = (hold_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the ui_in[7:4] push buttons into debounced levels and press/release pulses.
// Define BTN_LONG_PRESS_EN to enable the btn_long pulse; otherwise btn_long is tied low.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = BTN_N_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = BTN_LONG_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic             any_press
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_long    (btn_long[i])
        );
    end

    assign any_press = |btn_press;

endmodule
